ads5404_ctrl: RTL
=================

# ads5404_ctrl

Bring-up and resynchronisation sequencer for the ADS5404 dual-ADC capture interface. Runs on a free-running fabric clock and drives the capture block's `user_rst`, `user_enable` and `user_sync` controls. Waits for the capture PLL to lock, issues the ADC SYNC pulse and confirms that the sync returns on the data path. Retries with bounded attempts and reports status to software/user logic.

## Interface
- `RST_CYCLES`, 64: cycles `user_rst` is held high in RESET (≥2).
- `LOCK_TIMEOUT`, 65536: maximum cycles spent in WAIT_LOCK.
- `EN_SETTLE`, 256: cycles between asserting `user_enable` and issuing sync.
- `SYNC_CYCLES`, 8: width of the `user_sync` pulse.
- `SYNC_TIMEOUT`, 1024: maximum cycles spent in WAIT_SYNC.
- `MAX_RETRY`, 3: failed attempts before entering FAIL (1..15).
- `clk` in 1: free-running control clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin or restart the full bring-up (single-cycle pulse).
- `resync` in 1: re-issue sync only (single-cycle pulse).
- `pll_locked` in 1: capture PLL lock; asynchronous, synchronised internally.
- `sync_det` in 1: OR of `sync_out_0`/`sync_out_1`, stretched by the capture domain; asynchronous.
- `user_rst` out 1: capture/ADC reset, active high.
- `user_enable` out 1: ADC enable.
- `user_sync` out 1: ADC SYNC request.
- `ready` out 1: high only in RUN.
- `busy` out 1: high in states RESET..WAIT_SYNC.
- `error` out 1: high only in FAIL.
- `state` out 3: current state encoding.
- `retry_cnt` out 4: failed attempts since last `start`.
- `lock_lost` out 1: sticky flag; set on PLL unlock in RUN; cleared by `start`.

## Operation
- `pll_locked` and `sync_det` each pass through a 2-flop synchroniser. `sync_det` additionally gets a rising-edge detector (3rd flop).
- States and encodings:
  - IDLE=0: all outputs at reset values. `start` -> RESET.
  - RESET=1: `user_rst`=1, `user_enable`=0. After exactly RST_CYCLES cycles -> WAIT_LOCK.
  - WAIT_LOCK=2: `user_rst`=0.
    - Synced lock high -> ENABLE.
    - Timeout after LOCK_TIMEOUT cycles -> retry.
  - ENABLE=3: `user_enable`=1. After EN_SETTLE cycles -> SYNC.
  - SYNC=4: `user_sync`=1 for exactly SYNC_CYCLES cycles -> WAIT_SYNC.
  - WAIT_SYNC=5:
    - Rising edge of synced `sync_det` -> RUN.
    - Timeout after SYNC_TIMEOUT cycles -> retry.
    - Edges seen during SYNC are ignored.
  - RUN=6: `ready`=1.
    - `resync` -> SYNC; `user_enable` stays 1, no reset.
    - Synced lock falling -> `lock_lost`=1; next state is set by the configured behaviour.
  - FAIL=7: `error`=1, `user_rst`=1, `user_enable`=0. Only `start` exits.
- Retry:
  - `retry_cnt` increments.
  - If the new value equals MAX_RETRY -> FAIL; otherwise -> RESET.
  - `retry_cnt` saturates at 15.
- `start` handling:
  - Accepted in IDLE, RUN and FAIL; ignored while `busy`.
  - On acceptance: `retry_cnt`=0, `lock_lost`=0, `error`=0 -> RESET.
  - `start` and `resync` in the same cycle: `start` wins.
  - `resync` outside RUN is ignored.
- A single down-counter, sized by `$clog2` of the largest timing parameter, is loaded on every state entry. The state advances on the cycle the counter reads 1. A state with parameter N therefore lasts exactly N cycles.

## Timing
- Reset values (asynchronous on `rst_n` low): state=IDLE, `user_rst`=1, `user_enable`=0, `user_sync`=0, `ready`=0, `busy`=0, `error`=0, `retry_cnt`=0, `lock_lost`=0, synchroniser flops=0.
- All outputs are registered.
- `start` sampled at edge k -> `state`=1 and `user_rst`=1 visible at k+1.
- `pll_locked` rising -> ENABLE 3 cycles later: 2 synchroniser cycles + 1 state register.
- `sync_det` rising -> RUN/`ready` 4 cycles later.
- `user_sync` is high exactly SYNC_CYCLES consecutive cycles per entry into SYNC.
- `rst_n` asserted mid-sequence: immediate return to reset values, including `user_rst`=1.
- PLL unlock during WAIT_SYNC/ENABLE/SYNC: no special action; the sequence completes or times out.

## Configuration
- `ADS5404_CTRL_AUTORECOVER_EN` defined: PLL unlock in RUN -> RESET. `retry_cnt` is unchanged; `lock_lost` is set.
- Not defined: PLL unlock in RUN -> stays in RUN with `ready`=1 and `lock_lost`=1. Software must pulse `start` to recover.

## Test plan
- Nominal bring-up:
  - Stimulus: `start`; `pll_locked` rises 100 cycles after `user_rst` falls; `sync_det` pulses 20 cycles after `user_sync` falls.
  - Required: `user_rst` high 64 cycles; `user_enable` high 256 cycles before `user_sync`; `user_sync` high 8 cycles; `ready`=1 four cycles after `sync_det`; `retry_cnt`=0.
- Lock timeout:
  - Stimulus: `pll_locked` held 0.
  - Required: three RESET/WAIT_LOCK attempts; `retry_cnt` reads 1, 2, 3; FAIL with `error`=1 and `user_rst`=1. A subsequent `start` clears `error`/`retry_cnt`.
- Sync timeout then success:
  - Stimulus: no `sync_det` on the first attempt, `sync_det` on the second.
  - Required: `retry_cnt`=1, `ready`=1; `user_rst` re-pulsed for 64 cycles between attempts.
- Resync in RUN:
  - Stimulus: `resync`.
  - Required: `ready` drops next cycle; `user_sync` high 8 cycles; `user_enable` stays 1; `user_rst` stays 0; `sync_det` -> RUN.
- Unlock in RUN:
  - Stimulus: drop `pll_locked`, checked with and without `ADS5404_CTRL_AUTORECOVER_EN`.
  - Required: `lock_lost`=1 three cycles later. With the macro, state=RESET; without it, state stays 6.
- Async reset during SYNC:
  - Stimulus: `rst_n`=0 for 1 cycle.
  - Required: `user_sync`=0, `user_rst`=1, state=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ads5404_ctrl.sv
// rtl/ads5404_ctrl.sv - ADS5404 capture bring-up/resync sequencer (option: ADS5404_CTRL_AUTORECOVER_EN)
module ads5404_ctrl #(
   parameter int RST_CYCLES   = 64,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int EN_SETTLE    = 256,
   parameter int SYNC_CYCLES  = 8,
   parameter int SYNC_TIMEOUT = 1024,
   parameter int MAX_RETRY    = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       resync,
   input  logic       pll_locked,
   input  logic       sync_det,
   output logic       user_rst,
   output logic       user_enable,
   output logic       user_sync,
   output logic       ready,
   output logic       busy,
   output logic       error,
   output logic [2:0] state,
   output logic [3:0] retry_cnt,
   output logic       lock_lost
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RESET     = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_ENABLE    = 3'd3,
      ST_SYNC      = 3'd4,
      ST_WAIT_SYNC = 3'd5,
      ST_RUN       = 3'd6,
      ST_FAIL      = 3'd7
   } state_t;

   localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_B = (EN_SETTLE > SYNC_CYCLES) ? EN_SETTLE : SYNC_CYCLES;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAXP  = (MAX_C > SYNC_TIMEOUT) ? MAX_C : SYNC_TIMEOUT;
   localparam int CW    = $clog2(MAXP + 1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_load;
   logic            w_cnt_last;
   logic [3:0]      r_retry_cnt;
   logic [3:0]      w_retry_nxt;
   logic [3:0]      w_retry_inc;
   logic            r_lock_lost;
   logic            w_lock_lost_nxt;
   logic            w_start_ok;

   logic            r_lock_s1;
   logic            r_lock_s2;
   logic            r_sdet_s1;
   logic            r_sdet_s2;
   logic            r_sdet_s3;
   logic            r_sdet_rise;

   logic            r_user_rst;
   logic            r_user_enable;
   logic            r_user_sync;
   logic            r_ready;
   logic            r_busy;
   logic            r_error;

   // Bring async PLL lock and sync return into clk; register the sync rising edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_s1   <= 1'b0;
         r_lock_s2   <= 1'b0;
         r_sdet_s1   <= 1'b0;
         r_sdet_s2   <= 1'b0;
         r_sdet_s3   <= 1'b0;
         r_sdet_rise <= 1'b0;
      end else begin
         r_lock_s1   <= pll_locked;
         r_lock_s2   <= r_lock_s1;
         r_sdet_s1   <= sync_det;
         r_sdet_s2   <= r_sdet_s1;
         r_sdet_s3   <= r_sdet_s2;
         r_sdet_rise <= r_sdet_s2 & ~r_sdet_s3;
      end
   end

   assign w_cnt_last  = (r_cnt == CW'(1));
   assign w_retry_inc = (r_retry_cnt == 4'd15) ? 4'd15 : r_retry_cnt + 4'd1;
   assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_FAIL));

   // Next-state, retry accounting and sticky lock-loss decision
   always_comb begin
      w_state_nxt     = r_state;
      w_retry_nxt     = r_retry_cnt;
      w_lock_lost_nxt = r_lock_lost;
      if (w_start_ok) begin
         w_state_nxt     = ST_RESET;
         w_retry_nxt     = 4'd0;
         w_lock_lost_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_RESET: begin
               if (w_cnt_last) w_state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (r_lock_s2) begin
                  w_state_nxt = ST_ENABLE;
               end else if (w_cnt_last) begin
                  w_retry_nxt = w_retry_inc;
                  w_state_nxt = (w_retry_inc == 4'(MAX_RETRY)) ? ST_FAIL : ST_RESET;
               end
            end
            ST_ENABLE: begin
               if (w_cnt_last) w_state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
               if (w_cnt_last) w_state_nxt = ST_WAIT_SYNC;
            end
            ST_WAIT_SYNC: begin
               if (r_sdet_rise) begin
                  w_state_nxt = ST_RUN;
               end else if (w_cnt_last) begin
                  w_retry_nxt = w_retry_inc;
                  w_state_nxt = (w_retry_inc == 4'(MAX_RETRY)) ? ST_FAIL : ST_RESET;
               end
            end
            ST_RUN: begin
               if (!r_lock_s2) w_lock_lost_nxt = 1'b1;
`ifdef ADS5404_CTRL_AUTORECOVER_EN
               if (!r_lock_s2) begin
                  w_state_nxt = ST_RESET;
               end else if (resync) begin
                  w_state_nxt = ST_SYNC;
               end
`else
               if (resync) w_state_nxt = ST_SYNC;
`endif
            end
            default: begin
               w_state_nxt = r_state;
            end
         endcase
      end
   end

   // Duration loaded into the shared down-counter on entry to each state
   always_comb begin
      w_cnt_load = '0;
      case (w_state_nxt)
         ST_RESET:     w_cnt_load = CW'(RST_CYCLES);
         ST_WAIT_LOCK: w_cnt_load = CW'(LOCK_TIMEOUT);
         ST_ENABLE:    w_cnt_load = CW'(EN_SETTLE);
         ST_SYNC:      w_cnt_load = CW'(SYNC_CYCLES);
         ST_WAIT_SYNC: w_cnt_load = CW'(SYNC_TIMEOUT);
         default:      w_cnt_load = '0;
      endcase
   end

   // State register, shared counter, retry count and sticky lock-loss flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_retry_cnt <= 4'd0;
         r_lock_lost <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_retry_cnt <= w_retry_nxt;
         r_lock_lost <= w_lock_lost_nxt;
         if (w_state_nxt != r_state) begin
            r_cnt <= w_cnt_load;
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

   // Control outputs registered from the upcoming state so they align with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_user_rst    <= 1'b1;
         r_user_enable <= 1'b0;
         r_user_sync   <= 1'b0;
         r_ready       <= 1'b0;
         r_busy        <= 1'b0;
         r_error       <= 1'b0;
      end else begin
         r_user_rst    <= (w_state_nxt inside {ST_IDLE, ST_RESET, ST_FAIL});
         r_user_enable <= (w_state_nxt inside {ST_ENABLE, ST_SYNC, ST_WAIT_SYNC, ST_RUN});
         r_user_sync   <= (w_state_nxt == ST_SYNC);
         r_ready       <= (w_state_nxt == ST_RUN);
         r_busy        <= (w_state_nxt inside {ST_RESET, ST_WAIT_LOCK, ST_ENABLE, ST_SYNC, ST_WAIT_SYNC});
         r_error       <= (w_state_nxt == ST_FAIL);
      end
   end

   assign user_rst    = r_user_rst;
   assign user_enable = r_user_enable;
   assign user_sync   = r_user_sync;
   assign ready       = r_ready;
   assign busy        = r_busy;
   assign error       = r_error;
   assign state       = r_state;
   assign retry_cnt   = r_retry_cnt;
   assign lock_lost   = r_lock_lost;

endmodule
